// File: rtl/jacobi_host_streamer.sv
// Host-side shim for a Jacobi solver: streams src_buf out, captures the result into res_buf.
// Define JHS_TIMEOUT_EN to add a watchdog on the solver result phase (sets sticky err_timeout).
module jacobi_host_streamer #(
  parameter int M              = 4,
  parameter int MEM_SIZE       = (M + 2) * (M + 2),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [9:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [31:0] h_in,
  input  logic        go,
  input  logic [9:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        sol_start,
  output logic [31:0] sol_h,
  output logic [31:0] sol_u_data_in,
  output logic        sol_u_data_valid,
  input  logic [31:0] sol_u_data_out,
  input  logic        sol_u_data_out_valid,
  input  logic        sol_done
);

  localparam int              AW       = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int              PW       = $clog2(MEM_SIZE + 1);
  localparam logic [9:0]      ADDR_LIM = 10'(MEM_SIZE);
  localparam logic [AW-1:0]   LAST     = AW'(MEM_SIZE - 1);
  localparam logic [PW-1:0]   RD_END   = PW'(MEM_SIZE);

  typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, CAPTURE, FIN} state_t;

  state_t        state;
  logic [31:0]   src_buf [MEM_SIZE];
  logic [31:0]   res_buf [MEM_SIZE];
  logic [PW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          sol_done_q;
  logic          done_rise;
  logic          res_we;
  logic [AW-1:0] res_wa;
  logic          tmo_fire;

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign done_rise = sol_done & ~sol_done_q;
  assign rd_data   = (rd_addr < ADDR_LIM) ? res_buf[rd_addr[AW-1:0]] : 32'd0;

  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we && cfg_addr < ADDR_LIM)
      src_buf[cfg_addr[AW-1:0]] <= cfg_wdata;
  end

  // The last word arrives with valid low alongside the done edge; extra valid words are dropped.
  always_comb begin
    res_we = 1'b0;
    res_wa = wptr;
    if (done_rise) begin
      if (state == CAPTURE && wptr == LAST)
        res_we = 1'b1;
    end else if (sol_u_data_out_valid) begin
      if (state == WAIT) begin
        res_we = 1'b1;
        res_wa = '0;
      end else if (state == CAPTURE && wptr != LAST) begin
        res_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res_we)
      res_buf[res_wa] <= sol_u_data_out;
  end

`ifdef JHS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting  = (state == WAIT) || (state == CAPTURE);
  assign tmo_fire = waiting && !done_rise && !res_we && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!waiting || res_we)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == IDLE && go)
        err_timeout <= 1'b0;
      else if (tmo_fire)
        err_timeout <= 1'b1;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sol_start        <= 1'b0;
      sol_h            <= '0;
      sol_u_data_in    <= '0;
      sol_u_data_valid <= 1'b0;
      rptr             <= '0;
      wptr             <= '0;
      sol_done_q       <= 1'b0;
    end else begin
      sol_done_q <= (state == START) ? 1'b0 : sol_done;
      case (state)
        IDLE: begin
          if (go) begin
            sol_h     <= h_in;
            sol_start <= 1'b1;
            state     <= START;
          end
        end
        // Word 0 is issued here so it lands on the first LOAD cycle; rptr counts words issued.
        START: begin
          sol_start        <= 1'b0;
          wptr             <= '0;
          rptr             <= PW'(1);
          sol_u_data_in    <= src_buf[0];
          sol_u_data_valid <= 1'b1;
          state            <= LOAD;
        end
        LOAD: begin
          if (rptr == RD_END) begin
            sol_u_data_valid <= 1'b0;
            state            <= WAIT;
          end else begin
            sol_u_data_in <= src_buf[rptr[AW-1:0]];
            rptr          <= rptr + 1'b1;
          end
        end
        WAIT: begin
          if (done_rise || tmo_fire) begin
            state <= FIN;
          end else if (res_we) begin
            wptr  <= AW'(1);
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (done_rise || tmo_fire)
            state <= FIN;
          else if (res_we)
            wptr <= wptr + 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jacobi_host_streamer.md
JACOBI_HOST_STREAMER -- requirements
Module: jacobi_host_streamer

Interface
REQ-001 The block SHALL have parameter M, default 4, interior grid dimension.
REQ-002 The block SHALL have parameter MEM_SIZE, default (M+2)*(M+2), words per grid including boundary.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit in clocks.
REQ-004 The block SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port cfg_we, cfg_addr, cfg_wdata  input  1/10/32  host write into the source grid buffer.
REQ-007 The block SHALL have port h_in  input  32  grid spacing, latched at go.
REQ-008 The block SHALL have port go  input  1  one-cycle transaction request.
REQ-009 The block SHALL have port rd_addr  input  10 and port rd_data  output  32, combinational read of the result buffer.
REQ-010 The block SHALL have port busy  output  1, done  output  1 (one-cycle pulse) and err_timeout  output  1 (sticky).
REQ-011 The block SHALL have solver-side outputs sol_start 1, sol_h 32, sol_u_data_in 32 and sol_u_data_valid 1.
REQ-012 The block SHALL have solver-side inputs sol_u_data_out 32, sol_u_data_out_valid 1 and sol_done 1 (level; rises at end of solver output).

Function
REQ-013 States SHALL be IDLE, START, LOAD, WAIT, CAPTURE and FIN; busy SHALL be 1 in every state except IDLE.
REQ-014 In IDLE, cfg_we SHALL write src_buf[cfg_addr]; cfg_we in any other state SHALL be ignored; cfg_addr >= MEM_SIZE SHALL be ignored.
REQ-015 go in IDLE SHALL latch h_in into sol_h and move to START; go in any other state SHALL be ignored.
REQ-016 START SHALL assert sol_start for exactly one cycle, clear the read and write pointers, then move to LOAD.
REQ-017 LOAD SHALL drive sol_u_data_valid=1 with sol_u_data_in=src_buf[ptr] on MEM_SIZE consecutive cycles, words 0..MEM_SIZE-1 in order with no gaps; the first word SHALL be on the cycle after sol_start.
REQ-018 After word MEM_SIZE-1, sol_u_data_valid SHALL drop to 0 and the state SHALL move to WAIT.
REQ-019 WAIT SHALL move to CAPTURE on the first cycle sol_u_data_out_valid=1, capturing that word at res_buf[0].
REQ-020 In CAPTURE, each cycle with sol_u_data_out_valid=1 SHALL write res_buf[wptr] and increment wptr.
REQ-021 On a rising edge of sol_done with wptr==MEM_SIZE-1, sol_u_data_out SHALL be captured into res_buf[MEM_SIZE-1]; the solver presents the final word with valid=0 alongside done.
REQ-022 A rising edge of sol_done with wptr != MEM_SIZE-1 SHALL write nothing further and SHALL still complete through FIN.
REQ-023 Valid words beyond MEM_SIZE-1 SHALL be dropped; wptr SHALL saturate and never wrap.
REQ-024 FIN SHALL pulse done for one cycle and return to IDLE; rd_data SHALL be valid from the done cycle onward.
REQ-025 Rising-edge detection of sol_done SHALL use a registered copy of sol_done that is cleared in START.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE and sol_start, sol_u_data_valid, busy, done and err_timeout SHALL all be 0.
REQ-027 While rst_n=0, sol_h, sol_u_data_in and all pointers SHALL be 0.
REQ-028 Buffer contents SHALL NOT be reset.
REQ-029 Reset mid-transaction SHALL abort immediately with no done pulse.

Configuration
REQ-030 With JHS_TIMEOUT_EN defined, a counter SHALL run in WAIT and CAPTURE and clear on every captured word.
REQ-031 With JHS_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set err_timeout and go to FIN.
REQ-032 err_timeout SHALL clear only on reset or the next accepted go.
REQ-033 Without JHS_TIMEOUT_EN, no counter SHALL exist, err_timeout SHALL be tied 0, and WAIT SHALL persist indefinitely.

Verification
REQ-034 Load src_buf[i]=i, go -> one sol_start pulse, then 36 contiguous valid words 0..35 starting the next cycle.
REQ-035 Solver model returns words 100+i, i=0..34 with valid and word 135 with done -> res_buf[i]=100+i for all 36 words, one done pulse.
REQ-036 go and cfg_we (addr 3, data FFFF) issued during LOAD -> both ignored, src_buf[3] unchanged, stream unchanged.
REQ-037 Assert rst_n=0 at load word 10 -> busy=0, sol_u_data_valid=0 next edge, no done pulse; a fresh go then restarts at word 0.
REQ-038 With JHS_TIMEOUT_EN defined and TIMEOUT_CYCLES=50, solver silent -> err_timeout=1 and done pulse 50 cycles after entering WAIT.
REQ-039 Solver sends 40 valid words then done -> words 36+ dropped, res_buf[35] holds the value present at sol_done rise.
